// File: rtl/fpu_pkg.sv
// fpu_pkg: shared state encoding, normalize selects and loop bounds for the FP add sequencer.
// Rev 1.0
`default_nettype none

package fpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COMPARE = 3'd1,
    ST_ALIGN   = 3'd2,
    ST_SUM     = 3'd3,
    ST_NORM    = 3'd4,
    ST_ROUND   = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  localparam logic [1:0] SEL_NORM_HOLD  = 2'b00;
  localparam logic [1:0] SEL_NORM_RIGHT = 2'b01;
  localparam logic [1:0] SEL_NORM_LEFT  = 2'b10;

  // Beyond man_w+3 positions every mantissa bit has already fallen into sticky.
  function automatic int align_max(input int man_w);
    return man_w + 3;
  endfunction

  function automatic int norm_max(input int man_w);
    return man_w + 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fpu_sat_downcnt.sv
// fpu_sat_downcnt: loadable down-counter that sticks at zero, with a count==1 flag.
// Rev 1.0
`default_nettype none

module fpu_sat_downcnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         is_one
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign is_one = (count == W'(1));

endmodule

`default_nettype wire

// File: rtl/fpu_add_seq.sv
// fpu_add_seq: multi-cycle control sequencer for the FP adder datapath.
// Rev 1.0
`default_nettype none

module fpu_add_seq
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ack,
  input  logic signed [EXP_W:0] exp_diff,
  input  logic [1:0]        lead_bits,
  input  logic              is_zero,
  input  logic              round_carry,
  output logic              load_ops,
  output logic              swap,
  output logic              align_shift,
  output logic              sum_en,
  output logic [1:0]        sel_norm,
  output logic              round_en,
  output logic              busy,
  output logic              done,
  output logic              zero_result
);

  localparam int ALIGN_MAX = align_max(MAN_W);
  localparam int NORM_MAX  = norm_max(MAN_W);
  localparam int CNT_W     = $clog2(ALIGN_MAX + 1);
  localparam int NCNT_W    = $clog2(NORM_MAX + 1);
  localparam logic [EXP_W:0]  ALIGN_MAX_E = (EXP_W+1)'(ALIGN_MAX);
  localparam logic [NCNT_W-1:0] NORM_LAST = NCNT_W'(NORM_MAX - 1);

  state_t              state;
  logic [NCNT_W-1:0]   norm_cnt;
  logic                rnd_pass;

  logic                diff_neg;
  logic [EXP_W:0]      diff_mag;
  logic [CNT_W-1:0]    align_load;
  logic [CNT_W-1:0]    align_cnt;
  logic                align_last;

  // Unsigned magnitude so that -2^EXP_W maps to 2^EXP_W and saturates like any large shift.
  assign diff_neg   = exp_diff[EXP_W];
  assign diff_mag   = diff_neg ? (~$unsigned(exp_diff) + 1'b1) : $unsigned(exp_diff);
  assign align_load = (diff_mag > ALIGN_MAX_E) ? CNT_W'(ALIGN_MAX) : CNT_W'(diff_mag);

  fpu_sat_downcnt #(
    .W (CNT_W)
  ) u_align_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (state == ST_COMPARE),
    .load_val (align_load),
    .dec      (state == ST_ALIGN),
    .count    (align_cnt),
    .is_one   (align_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      norm_cnt    <= '0;
      rnd_pass    <= 1'b0;
      swap        <= 1'b0;
      zero_result <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_COMPARE;
            rnd_pass    <= 1'b0;
            norm_cnt    <= '0;
            zero_result <= 1'b0;
          end
        end
        ST_COMPARE: begin
          swap  <= diff_neg;
          state <= (diff_mag == '0) ? ST_SUM : ST_ALIGN;
        end
        ST_ALIGN: begin
          // A zero count can only appear after an upset; leave rather than stall.
          if (align_last || (align_cnt == '0)) begin
            state <= ST_SUM;
          end
        end
        ST_SUM: begin
          state <= ST_NORM;
        end
        ST_NORM: begin
          if (lead_bits[1]) begin
            state <= ST_NORM;
          end else if (lead_bits[0]) begin
            state <= ST_ROUND;
          end else if (is_zero) begin
            zero_result <= 1'b1;
            state       <= ST_DONE;
          end else begin
            norm_cnt <= norm_cnt + 1'b1;
            if (norm_cnt == NORM_LAST) begin
              zero_result <= 1'b1;
              state       <= ST_DONE;
            end
          end
        end
        ST_ROUND: begin
          if (round_carry && !rnd_pass) begin
            rnd_pass <= 1'b1;
            state    <= ST_NORM;
          end else begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (ack) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    load_ops    = 1'b0;
    align_shift = 1'b0;
    sum_en      = 1'b0;
    sel_norm    = SEL_NORM_HOLD;
    round_en    = 1'b0;
    busy        = (state != ST_IDLE) && (state != ST_DONE);
    done        = (state == ST_DONE);
    case (state)
      ST_IDLE:  load_ops    = start;
      ST_ALIGN: align_shift = 1'b1;
      ST_SUM:   sum_en      = 1'b1;
      ST_NORM: begin
        if (lead_bits[1]) begin
          sel_norm = SEL_NORM_RIGHT;
        end else if (!lead_bits[0] && !is_zero) begin
          sel_norm = SEL_NORM_LEFT;
        end
      end
      ST_ROUND: round_en = 1'b1;
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_fpu_add_seq.sv
// tb_fpu_add_seq: randomized timeline checks of the FP add sequencer against a behavioural model.
// Rev 1.0
`default_nettype none

module tb_fpu_add_seq;

  localparam int DEPTH     = 256;
  localparam int ALIGN_MAX = 26;
  localparam int NORM_MAX  = 25;

  localparam logic [7:0] V_LOAD  = 8'h80;
  localparam logic [7:0] V_ALIGN = 8'h40;
  localparam logic [7:0] V_SUM   = 8'h20;
  localparam logic [7:0] V_LEFT  = 8'h10;
  localparam logic [7:0] V_RIGHT = 8'h08;
  localparam logic [7:0] V_ROUND = 8'h04;
  localparam logic [7:0] V_BUSY  = 8'h02;
  localparam logic [7:0] V_DONE  = 8'h01;

  logic clk = 1'b0;
  logic reset, start, ack, is_zero, round_carry;
  logic signed [8:0] exp_diff;
  logic [1:0] lead_bits;
  logic load_ops, swap, align_shift, sum_en, round_en, busy, done, zero_result;
  logic [1:0] sel_norm;
  logic [7:0] obs_vec;

  assign obs_vec = {load_ops, align_shift, sum_en, sel_norm, round_en, busy, done};

  fpu_add_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ack         (ack),
    .exp_diff    (exp_diff),
    .lead_bits   (lead_bits),
    .is_zero     (is_zero),
    .round_carry (round_carry),
    .load_ops    (load_ops),
    .swap        (swap),
    .align_shift (align_shift),
    .sum_en      (sum_en),
    .sel_norm    (sel_norm),
    .round_en    (round_en),
    .busy        (busy),
    .done        (done),
    .zero_result (zero_result)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-cycle stimulus and expected strobes for one operation.
  bit         st_start [DEPTH];
  bit         st_ack   [DEPTH];
  bit         st_zero  [DEPTH];
  bit         st_carry [DEPTH];
  logic [1:0] st_lead  [DEPTH];
  logic [8:0] st_diff  [DEPTH];
  logic [7:0] ev       [DEPTH];
  bit         chk      [DEPTH];
  int         len;
  bit         exp_swap;
  bit         exp_zr;

  // Datapath behaviour script: each entry is {is_zero, lead_bits} for one NORM cycle.
  logic [2:0] scr[$];
  bit         car[$];

  task automatic build_op(input int d, input int ackw, input bit noise);
    int t, mag, a, left;
    bit rp, fin, c;
    logic [2:0] v;
    for (int i = 0; i < DEPTH; i++) begin
      st_start[i] = noise && ($urandom_range(0, 3) == 0);
      st_ack[i]   = noise && ($urandom_range(0, 1) == 1);
      st_lead[i]  = noise ? 2'($urandom) : 2'b01;
      st_zero[i]  = noise && ($urandom_range(0, 1) == 1);
      st_carry[i] = noise && ($urandom_range(0, 1) == 1);
      st_diff[i]  = noise ? 9'($urandom) : 9'(d);
      ev[i]       = 8'h00;
      chk[i]      = 1'b0;
    end
    st_start[0] = 1'b1;
    ev[0]       = V_LOAD;
    st_diff[1]  = 9'(d);
    ev[1]       = V_BUSY;
    t   = 2;
    mag = (d < 0) ? -d : d;
    a   = (mag > ALIGN_MAX) ? ALIGN_MAX : mag;
    for (int i = 0; i < a; i++) begin
      ev[t] = V_ALIGN | V_BUSY;
      t++;
    end
    ev[t] = V_SUM | V_BUSY;
    t++;
    left = 0; rp = 0; fin = 0; exp_zr = 0;
    while (!fin) begin
      v = (scr.size() > 0) ? scr.pop_front() : 3'b001;
      st_lead[t] = v[1:0];
      st_zero[t] = v[2];
      if (v[1]) begin
        ev[t] = V_RIGHT | V_BUSY;
        t++;
      end else if (v[0]) begin
        ev[t] = V_BUSY;
        t++;
        c = (car.size() > 0) ? car.pop_front() : 1'b0;
        st_carry[t] = c;
        ev[t] = V_ROUND | V_BUSY;
        t++;
        if (c && !rp) rp = 1'b1;
        else fin = 1'b1;
      end else if (v[2]) begin
        ev[t] = V_BUSY;
        t++;
        exp_zr = 1'b1;
        fin = 1'b1;
      end else begin
        ev[t] = V_LEFT | V_BUSY;
        t++;
        left++;
        if (left == NORM_MAX) begin
          exp_zr = 1'b1;
          fin = 1'b1;
        end
      end
    end
    for (int k = 0; k <= ackw; k++) begin
      st_ack[t] = (k == ackw);
      ev[t]     = V_DONE;
      chk[t]    = 1'b1;
      t++;
    end
    st_start[t] = 1'b0;
    ev[t] = 8'h00;
    t++;
    len = t;
    exp_swap = (d < 0);
  endtask

  task automatic drive(input int t);
    start       = st_start[t];
    ack         = st_ack[t];
    exp_diff    = st_diff[t];
    lead_bits   = st_lead[t];
    is_zero     = st_zero[t];
    round_carry = st_carry[t];
  endtask

  task automatic run_op(input string name);
    for (int t = 0; t < len; t++) begin
      drive(t);
      @(negedge clk);
      check_eq($sformatf("%s c%0d strobes", name, t), 32'(obs_vec), 32'(ev[t]));
      if (chk[t]) begin
        check_eq($sformatf("%s c%0d swap", name, t), 32'(swap), 32'(exp_swap));
        check_eq($sformatf("%s c%0d zero_result", name, t), 32'(zero_result), 32'(exp_zr));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic gen_random();
    int n;
    scr.delete();
    car.delete();
    n = $urandom_range(0, 4);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 9) < 4) scr.push_back({1'($urandom), 1'b1, 1'($urandom)});
      else scr.push_back(3'b000);
    end
    scr.push_back(($urandom_range(0, 4) == 0) ? 3'b100 : {1'($urandom), 2'b01});
    n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) begin
      scr.push_back(($urandom_range(0, 1) == 1) ? 3'b010 : 3'b000);
    end
    scr.push_back(3'b001);
    car.push_back(1'($urandom));
    car.push_back(1'($urandom));
  endtask

  function automatic int rand_diff();
    case ($urandom_range(0, 3))
      0: return 0;
      1: return $urandom_range(0, 60) - 30;
      2: return int'($urandom_range(0, 511)) - 256;
      default: return ($urandom_range(0, 1) == 1) ? -256 : 255;
    endcase
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; ack = 1'b0; exp_diff = '0;
    lead_bits = 2'b00; is_zero = 1'b0; round_carry = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    @(negedge clk);
    check_eq("reset strobes", 32'(obs_vec & ~V_LOAD), 32'h0);
    check_eq("reset swap", 32'(swap), 32'h0);
    check_eq("reset zero_result", 32'(zero_result), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_eq("post-reset idle strobes", 32'(obs_vec), 32'h0);
    @(posedge clk);
    #1;

    scr.delete(); car.delete();
    build_op(0, 2, 1'b0);
    run_op("min_latency");

    scr.delete(); car.delete();
    build_op(-5, 0, 1'b1);
    run_op("diff_m5");

    scr.delete(); car.delete();
    build_op(40, 1, 1'b1);
    run_op("diff_p40");

    scr.delete(); car.delete();
    build_op(-256, 0, 1'b1);
    run_op("diff_m256");

    scr.delete(); car.delete();
    scr.push_back(3'b010); scr.push_back(3'b001);
    build_op(0, 0, 1'b1);
    run_op("norm_right");

    scr.delete(); car.delete();
    scr.push_back(3'b000); scr.push_back(3'b000); scr.push_back(3'b000); scr.push_back(3'b001);
    build_op(0, 0, 1'b1);
    run_op("norm_left3");

    scr.delete(); car.delete();
    scr.push_back(3'b001); scr.push_back(3'b010); scr.push_back(3'b001);
    car.push_back(1'b1); car.push_back(1'b1);
    build_op(3, 1, 1'b1);
    run_op("round_carry2");

    scr.delete(); car.delete();
    scr.push_back(3'b100);
    build_op(0, 0, 1'b1);
    run_op("is_zero");

    scr.delete(); car.delete();
    for (int i = 0; i < 30; i++) scr.push_back(3'b000);
    build_op(0, 1, 1'b1);
    run_op("norm_stuck");

    // Reset while aligning: sequencer returns to idle with every strobe low.
    scr.delete(); car.delete();
    build_op(-10, 0, 1'b0);
    for (int t = 0; t < 5; t++) begin
      drive(t);
      if (t == 4) reset = 1'b1;
      @(negedge clk);
      check_eq($sformatf("midreset c%0d strobes", t), 32'(obs_vec), 32'(ev[t]));
      if (t == 4) check_eq("midreset swap before", 32'(swap), 32'h1);
      @(posedge clk);
      #1;
    end
    reset = 1'b0; start = 1'b0; ack = 1'b0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check_eq($sformatf("midreset idle%0d strobes", t), 32'(obs_vec), 32'h0);
      check_eq($sformatf("midreset idle%0d swap", t), 32'(swap), 32'h0);
      check_eq($sformatf("midreset idle%0d zero_result", t), 32'(zero_result), 32'h0);
      @(posedge clk);
      #1;
    end

    for (int n = 0; n < 40; n++) begin
      gen_random();
      build_op(rand_diff(), $urandom_range(0, 3), 1'b1);
      run_op($sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fpu_add_seq.md
Name: fpu_add_seq

Overview:
Multi-cycle sequencer for the FP adder datapath. Accepts a start pulse and compares exponents. It then drives right-alignment of the smaller mantissa one bit per cycle, enables the sum, and runs a normalize loop. It finishes with a round pass, and a one-time renormalize if rounding carries out. It sits between the issue logic (start/ack handshake) and the adder datapath (mantissa registers, shifters, exponent adjust), and replaces the simple add control unit.

Parameters:
EXP_W, 8, exponent width; exp_diff is EXP_W+1 bits signed
MAN_W, 23, stored mantissa width; max alignment shift ALIGN_MAX = MAN_W+3 (26)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  begin operation; honoured only in IDLE
ack  in  1  result consumed; honoured only in DONE
exp_diff  in  EXP_W+1  signed expA-expB from datapath, sampled in COMPARE
lead_bits  in  2  sum mantissa bits left of binary point (b1 overflow, b0 hidden one)
is_zero  in  1  sum mantissa is all zero
round_carry  in  1  rounding overflowed mantissa, sampled in ROUND
load_ops  out  1  datapath captures operands this cycle
swap  out  1  registered; 1 = operand B has larger exponent
align_shift  out  1  shift smaller mantissa right 1 with sticky this cycle
sum_en  out  1  capture add/sub result
sel_norm  out  2  00 hold, 01 shift right/exp+1, 10 shift left/exp-1
round_en  out  1  apply rounding this cycle
busy  out  1  state not IDLE and not DONE
done  out  1  result valid; held until ack
zero_result  out  1  registered; result forced to signed zero

Behaviour:
- Reset: state IDLE, align_cnt=0, norm_cnt=0, rnd_pass=0, swap=0, zero_result=0. All outputs 0.
- Reset mid-operation: IDLE on the next edge, with no further strobes.
- Moore outputs, decoded from the state register; sel_norm also decodes lead_bits.
- States: IDLE, COMPARE, ALIGN, SUM, NORM, ROUND, DONE.
- IDLE:
  - load_ops = start.
  - start → COMPARE. Clear rnd_pass, norm_cnt, zero_result.
- COMPARE:
  - swap <= exp_diff<0.
  - align_cnt <= min(|exp_diff|, ALIGN_MAX). |−2^EXP_W| saturates the same way.
  - Next state is SUM if the magnitude is 0, else ALIGN.
- ALIGN:
  - align_shift=1; align_cnt decrements.
  - When align_cnt==1 → SUM. Exactly min(|d|,26) shift cycles.
- SUM: sum_en=1 → NORM.
- NORM, priority order:
  - lead_bits[1]: sel_norm=01, stay.
  - lead_bits[0]: sel_norm=00 → ROUND.
  - is_zero: zero_result<=1 → DONE, skip ROUND.
  - else: sel_norm=10, norm_cnt++, stay. If norm_cnt reaches MAN_W+2, force zero_result<=1 → DONE.
- ROUND:
  - round_en=1.
  - round_carry && !rnd_pass → NORM, rnd_pass<=1.
  - Otherwise → DONE. A carry on the second pass is ignored.
- DONE: done=1; ack → IDLE. start is ignored until IDLE.
- start asserted while busy or in DONE is dropped, never queued.
- Latency, start sampled at cycle 0: done first high at cycle 5 + |d|sat + extra NORM cycles + (rounding renorm cycles).
- Minimum latency is 5: d=0, lead_bits=01, no carry.

Decomposition:
- Shared package fpu_pkg holds:
  - state enum encoding (3 bits);
  - SEL_NORM_HOLD/RIGHT/LEFT constants;
  - ALIGN_MAX and NORM_MAX derivations from MAN_W.
- One sub-module, fpu_sat_downcnt: loadable saturating down-counter with a ==1 flag, used for align_cnt.
- The FSM stays in fpu_add_seq.

Test Plan:
- Reset, then start with exp_diff=0, lead_bits=01, round_carry=0 → load_ops@0, COMPARE@1, sum_en@2, NORM@3, round_en@4, done@5 held until ack, IDLE after ack.
- exp_diff=−5 → swap=1, align_shift high exactly 5 consecutive cycles, done@10. Repeat with exp_diff=+40 → align_shift exactly 26 cycles, swap=0.
- lead_bits=10 on first NORM, then 01 → one cycle sel_norm=01, then ROUND. lead_bits=00 for 3 cycles then 01 → three sel_norm=10 cycles, done@8 with d=0.
- round_carry=1 on first ROUND → NORM, lead=10 gives one sel_norm=01 cycle, second ROUND with round_carry=1 → DONE (rnd_pass blocks a third pass).
- is_zero=1 with lead_bits=00 on first NORM → DONE next cycle, zero_result=1, round_en never asserted. Repeat with lead_bits stuck 00 and is_zero=0 → 25 sel_norm=10 cycles, then DONE with zero_result=1.
- reset asserted during ALIGN with d=10 → IDLE next edge, all outputs 0.
- start pulsed during busy and during DONE → ignored; only a start in IDLE launches a new operation.
